// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the byte-stream handshake, the instruction-memory write port and
// the status lines of the boot loader.
//   start      host -> loader  begin a new load (1-cycle pulse)
//   in_valid   host -> loader  in_data holds a valid byte
//   in_data    host -> loader  stream byte
//   in_ready   loader -> host  loader accepts a byte this cycle
//   wr_en      loader -> imem  write strobe, one cycle per word
//   wr_addr    loader -> imem  word address
//   wr_data    loader -> imem  big-endian instruction word
//   cpu_reset  loader -> core  hold the processor in reset
//   busy       loader -> host  load in progress
//   done       loader -> host  frame stored with a good checksum
//   error      loader -> host  frame rejected
// The slave modport is the loader's view; master is the host's view.
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  cpu_reset;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, done, error
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Receives a framed byte stream (length hi/lo, 4*N data bytes, XOR checksum),
// assembles big-endian 32-bit words and writes them from address 0 upward
// into the instruction memory. The processor is held in reset until a whole
// frame with a matching checksum has been stored.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   imem_boot_loader_if.slave (handshake, write port, status)
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    // Memory depth, one bit wider than the 16-bit length field so that a
    // 256-word (or larger) depth compares cleanly against N.
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    logic [2:0]            state_q,   state_d;
    logic [15:0]           len_q,     len_d;
    logic [ADDR_WIDTH-1:0] wordIdx_q, wordIdx_d;
    logic [1:0]            byteCnt_q, byteCnt_d;
    logic [23:0]           shift_q,   shift_d;
    logic [7:0]            xor_q,     xor_d;
    logic [ADDR_WIDTH-1:0] wrAddr_q,  wrAddr_d;
    logic [31:0]           wrData_q,  wrData_d;

    logic                  inReady;
    logic                  xfer;
    logic [15:0]           nVal;
    logic [15:0]           lastIdx;

    assign inReady = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
    assign xfer    = bus.in_valid && inReady;
    assign nVal    = {len_q[15:8], bus.in_data};
    assign lastIdx = len_q - 16'd1;

    // Next-state logic. Every register holds its value unless the current
    // state consumes a byte (or, in WRITE, advances the word index), so idle
    // cycles with in_valid low leave the loader untouched.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wordIdx_d = wordIdx_q;
        byteCnt_d = byteCnt_q;
        shift_d   = shift_q;
        xor_d     = xor_q;
        wrAddr_d  = wrAddr_q;
        wrData_d  = wrData_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d   = S_LEN_HI;
                    xor_d     = 8'd0;
                    byteCnt_d = 2'd0;
                    wordIdx_d = '0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = bus.in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                // Oversized frames are rejected here, before any write, so
                // the word address can never wrap.
                if (xfer) begin
                    len_d = nVal;
                    if ((nVal != 16'd0) && ({1'b0, nVal} <= DEPTH)) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    xor_d     = xor_q ^ bus.in_data;
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        wrData_d = {shift_q, bus.in_data};
                        wrAddr_d = wordIdx_q;
                        state_d  = S_WRITE;
                    end else begin
                        shift_d = {shift_q[15:0], bus.in_data};
                    end
                end
            end
            S_WRITE: begin
                // The index may wrap to zero after the last word of a
                // full-depth frame; it is not used again before CHECK.
                wordIdx_d = wordIdx_q + 1'b1;
                if (16'(wordIdx_q) == lastIdx) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = (bus.in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers. An asynchronous reset drops straight back to IDLE
    // with the core held in reset; memory already written is left alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= 16'd0;
            wordIdx_q <= '0;
            byteCnt_q <= 2'd0;
            shift_q   <= 24'd0;
            xor_q     <= 8'd0;
            wrAddr_q  <= '0;
            wrData_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wordIdx_q <= wordIdx_d;
            byteCnt_q <= byteCnt_d;
            shift_q   <= shift_d;
            xor_q     <= xor_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
        end
    end

    // Outputs decode from the state; address and data are registered and
    // held between strobes so only wr_en qualifies them.
    assign bus.in_ready  = inReady;
    assign bus.wr_en     = (state_q == S_WRITE);
    assign bus.wr_addr   = wrAddr_q;
    assign bus.wr_data   = wrData_q;
    assign bus.cpu_reset = (state_q != S_DONE);
    assign bus.busy      = inReady || (state_q == S_WRITE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.error     = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Drives framed byte streams into imem_boot_loader and compares the write
// port and status lines against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    // Reference model state: writes the frame must produce, in order.
    logic [AW-1:0] expAddrQ[$];
    logic [31:0]   expDataQ[$];

    // Writes observed during the current frame.
    int            capCount = 0;
    logic [AW-1:0] capAddr [0:255];
    logic [31:0]   capData [0:255];

    // Payload of the frame being sent.
    logic [31:0]   words   [0:255];

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // XOR of all data bytes of the first n words in the payload.
    function automatic logic [7:0] xorOfWords(input int n);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
        end
        return x;
    endfunction

    // Per-cycle compare: every strobe must match the next expected write,
    // the core reset must mirror done, and the loader must not accept a
    // byte while strobing.
    always @(negedge clk) begin
        logic [AW-1:0] a;
        logic [31:0]   d;
        if (!rst) begin
            if (bus.wr_en) begin
                if (capCount < 256) begin
                    capAddr[capCount] = bus.wr_addr;
                    capData[capCount] = bus.wr_data;
                end
                capCount++;
                if (expAddrQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedWrite actual addr=%h data=%h required=no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    a = expAddrQ.pop_front();
                    d = expDataQ.pop_front();
                    checkOutput("wrAddr", 32'(bus.wr_addr), 32'(a));
                    checkOutput("wrData", bus.wr_data, d);
                    checkOutput("readyDuringWrite", 32'(bus.in_ready), 32'd0);
                end
            end
            checkOutput("cpuResetVsDone", 32'(bus.cpu_reset), 32'(!bus.done));
        end
    end

    // Global watchdog so the run always terminates.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Offer one byte (after an optional random idle gap) and wait, bounded,
    // for the loader to accept it. Runs in the posedge+1 phase.
    task automatic applyStimulus(input logic [7:0] b, input int gapPct);
        bit   ok;
        bit   rdy;
        int   guard;
        while (int'($urandom_range(99)) < gapPct) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok    = 1'b0;
        guard = 0;
        while (!ok && guard < 50) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL handshakeTimeout actual=no accept required=accept byte %h", b);
        end
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Send one complete frame and check the outcome against the model.
    task automatic runFrame(input int n, input logic [15:0] lenField, input logic [7:0] chk,
                            input int gapPct, input bit midStart);
        int  nInt;
        bit  lenOk;
        bit  expDone;
        nInt  = int'(lenField);
        lenOk = (nInt >= 1) && (nInt <= (1 << AW));
        capCount = 0;
        if (lenOk) begin
            for (int i = 0; i < n; i++) begin
                expAddrQ.push_back(AW'(i));
                expDataQ.push_back(words[i]);
            end
        end
        pulseStart();
        checkOutput("busyAfterStart", 32'(bus.busy), 32'd1);
        checkOutput("cpuResetAfterStart", 32'(bus.cpu_reset), 32'd1);
        applyStimulus(lenField[15:8], gapPct);
        applyStimulus(lenField[7:0], gapPct);
        if (!lenOk) begin
            checkOutput("badLenError", 32'(bus.error), 32'd1);
            checkOutput("badLenBusy", 32'(bus.busy), 32'd0);
            checkOutput("badLenCpuReset", 32'(bus.cpu_reset), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            checkOutput("badLenNoWrites", 32'(capCount), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int k = 3; k >= 0; k--) begin
                applyStimulus(words[i][8*k +: 8], gapPct);
                if (midStart && i == 1 && k == 2) begin
                    pulseStart();
                    checkOutput("midStartBusy", 32'(bus.busy), 32'd1);
                end
            end
        end
        applyStimulus(chk, gapPct);
        expDone = (chk == xorOfWords(n));
        checkOutput("done", 32'(bus.done), 32'(expDone));
        checkOutput("error", 32'(bus.error), 32'(!expDone));
        checkOutput("cpuReset", 32'(bus.cpu_reset), 32'(!expDone));
        checkOutput("busyEnd", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("writesDrained", 32'(expAddrQ.size()), 32'd0);
        checkOutput("writeCount", 32'(capCount), 32'(n));
    endtask

    initial begin
        int n;
        int gap;
        logic [7:0] chk;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(posedge clk);

        // Reset values
        @(negedge clk);
        checkOutput("rstInReady",  32'(bus.in_ready),  32'd0);
        checkOutput("rstWrEn",     32'(bus.wr_en),     32'd0);
        checkOutput("rstWrAddr",   32'(bus.wr_addr),   32'd0);
        checkOutput("rstWrData",   bus.wr_data,        32'd0);
        checkOutput("rstCpuReset", 32'(bus.cpu_reset), 32'd1);
        checkOutput("rstBusy",     32'(bus.busy),      32'd0);
        checkOutput("rstDone",     32'(bus.done),      32'd0);
        checkOutput("rstError",    32'(bus.error),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word; checksum 20^01^00^01 = 20
        words[0] = 32'h20010001;
        checkOutput("modelXorPin", 32'(xorOfWords(1)), 32'h20);
        runFrame(1, 16'd1, 8'h20, 0, 1'b0);
        checkOutput("t1Addr", 32'(capAddr[0]), 32'd0);
        checkOutput("t1Data", capData[0], 32'h20010001);
        checkOutput("t1Done", 32'(bus.done), 32'd1);
        checkOutput("t1CpuReset", 32'(bus.cpu_reset), 32'd0);

        // Three words in order
        words[0] = 32'h20020001;
        words[1] = 32'h20010004;
        words[2] = 32'h0041182A;
        runFrame(3, 16'd3, xorOfWords(3), 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2Addr", 32'(capAddr[i]), 32'(i));
        end
        checkOutput("t2Data2", capData[2], 32'h0041182A);

        // Bad checksum
        words[0] = 32'h20010001;
        runFrame(1, 16'd1, 8'h22, 0, 1'b0);
        checkOutput("t3Error", 32'(bus.error), 32'd1);
        checkOutput("t3Done", 32'(bus.done), 32'd0);

        // Illegal lengths: zero and one past the depth
        runFrame(0, 16'h0000, 8'h00, 0, 1'b0);
        runFrame(257, 16'h0101, 8'h00, 0, 1'b0);

        // Gapped 4-word frame with an ignored start mid-frame
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        runFrame(4, 16'd4, xorOfWords(4), 50, 1'b1);

        // Full-depth frame
        for (int i = 0; i < 256; i++) words[i] = $urandom;
        runFrame(256, 16'd256, xorOfWords(256), 0, 1'b0);
        checkOutput("fullLastAddr", 32'(capAddr[255]), 32'd255);

        // Randomized frames, some with corrupted checksums
        for (int f = 0; f < 6; f++) begin
            n   = int'($urandom_range(1, 12));
            gap = int'($urandom_range(0, 60));
            for (int i = 0; i < n; i++) words[i] = $urandom;
            chk = xorOfWords(n);
            if ($urandom_range(2) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            runFrame(n, 16'(n), chk, gap, 1'(f[0]));
        end

        // Reset after the second data byte, then a clean reload
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        pulseStart();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(words[0][31:24], 0);
        applyStimulus(words[0][23:16], 0);
        rst = 1'b1;
        #1;
        checkOutput("midRstCpuReset", 32'(bus.cpu_reset), 32'd1);
        checkOutput("midRstInReady",  32'(bus.in_ready),  32'd0);
        checkOutput("midRstBusy",     32'(bus.busy),      32'd0);
        checkOutput("midRstWrData",   bus.wr_data,        32'd0);
        expAddrQ.delete();
        expDataQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        runFrame(2, 16'd2, xorOfWords(2), 20, 1'b0);
        checkOutput("reloadDone", 32'(bus.done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
